fdiv_arbiter: RTL
=================

# fdiv_arbiter

Round-robin front end that shares one pipelined fdiv datapath among N_REQ requesters (FPU issue ports). It accepts one division per cycle, drives the divider operands, resolves the special operands the divider does not handle (zero, infinity), and returns each result to its originating requester in issue order. It sits between the core-side FPU dispatch and the fdiv instance.

## Interface
- N_REQ, 2: number of requesters; must be at least 2.
- LATENCY, 2: cycles from div_x/div_y being driven to div_res being valid; must be at least 1.

- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept (one-hot or zero).
- req_x  in  32*N_REQ  dividend; requester i uses bits [32i+31:32i].
- req_y  in  32*N_REQ  divisor, packed the same way.
- rsp_valid  out  N_REQ  one-cycle pulse on the originating requester's bit.
- rsp_data  out  32  shared result bus; valid only when rsp_valid is nonzero.
- div_x  out  32  operand x to fdiv.
- div_y  out  32  operand y to fdiv.
- div_res  in  32  fdiv result.
- busy  out  1  high while any accepted operation has not yet produced its rsp_valid.

## Operation
- Arbitration:
  - Round-robin pointer `last` holds the index of the most recent grant; reset value is N_REQ-1, so requester 0 has first priority.
  - Each cycle, grant goes to the first i with req_valid[i] set, searching from last+1 and wrapping around.
  - req_ready = grant, combinational from req_valid and `last`.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high. Requesters must not make req_valid depend on req_ready.
  - `last` updates only on a transfer.
  - With no requests, nothing is granted and the pointer holds.
- Issue:
  - On a transfer, x and y are registered into the issue register that drives div_x/div_y.
  - Without a transfer, the issue register holds its value.
  - A tag {valid, id, special, spec_val} is pushed into a LATENCY+1 deep shift register. The shift register advances every cycle and gets a bubble (valid=0) when there is no transfer.
- Special-case classification, computed from the registered operands. Exponent 0 counts as zero (denormals flushed). s = sx^sy.
  - x zero, y zero: 0x7FC00000.
  - x inf, y inf: 0x7FC00000.
  - Any NaN operand (exp 255, mantissa nonzero): 0x7FC00000.
  - y zero, x finite nonzero: {s, 8'hFF, 23'b0}.
  - x inf, y finite: {s, 8'hFF, 23'b0}.
  - x zero, y nonzero finite: {s, 31'b0}.
  - y inf, x finite: {s, 31'b0}.
  - Otherwise special=0 and the divider result is used.
- Retire:
  - When the tag reaches the output stage, rsp_data <= special ? spec_val : div_res.
  - At the same time, rsp_valid <= one-hot(id) if valid, else 0.
  - There is no response backpressure. Requesters must sink rsp_valid in the cycle it is asserted.
- busy: OR of all tag valid bits in the shift register plus the output stage.

## Timing
- Accept in cycle 0.
- div_x/div_y carry the operands during cycle 1.
- div_res is sampled at the end of cycle LATENCY.
- rsp_valid/rsp_data are registered and visible in cycle LATENCY+1 (cycle 3 at the default).
- Throughput is one operation per cycle. Results retire strictly in accept order.
- Reset values: req_ready follows comb logic (0 while rstn low); rsp_valid 0; rsp_data 0; div_x 0; div_y 0; busy 0; all tags invalid; `last` N_REQ-1.
- Reset mid-operation: all in-flight tags are dropped and no rsp_valid is emitted for them. After rstn deasserts, the first grant goes to requester 0.
- Simultaneous requests: exactly one grant per cycle. A continuously requesting set of k requesters is each served once every k cycles.
- Pointer wrap: after granting N_REQ-1, the search starts at 0.

## Test plan
- Single request, divider result path: requester 0 sends x=0x40C00000, y=0x40000000 in cycle 0 → rsp_valid=01 and rsp_data=0x40400000 in cycle 3; busy high in cycles 1-3.
- Divide by zero: requester 1 sends x=0xBF800000, y=0x00000000 → rsp_data=0xFF800000 on rsp_valid=10. The 0/0 case returns 0x7FC00000.
- Round robin: both requesters hold req_valid for 6 cycles after reset → grants 0,1,0,1,0,1. Responses appear with matching rsp_valid bits on cycles 3-8.
- Back-to-back throughput: requester 0 alone issues 8 consecutive divisions, including one with y=inf and x=2.0 (result 0x00000000) → 8 responses on consecutive cycles, in order, with no bubbles.
- Reset mid-flight: issue 2 operations, pull rstn low in cycle 2 for one cycle → no rsp_valid is ever asserted for them. All outputs are at their reset values and busy is 0. A following request from requester 1 alone is granted immediately, with normal 3-cycle latency.

Source files
------------

// File: rtl/fdiv_arbiter.sv
// Round-robin front end sharing one pipelined fdiv among N_REQ requesters.
// Resolves zero/inf/NaN operands locally and returns results in issue order.
module fdiv_arbiter #(
  parameter int N_REQ   = 2,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_x,
  input  logic [32*N_REQ-1:0]  req_y,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [31:0]          div_x,
  output logic [31:0]          div_y,
  input  logic [31:0]          div_res,
  output logic                 busy
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

  // Returns {special, value}; exponent 0 is treated as zero (denormals flushed).
  function automatic logic [32:0] classify(input logic [31:0] x, input logic [31:0] y);
    logic s, xz, yz, xi, yi, nan;
    s   = x[31] ^ y[31];
    xz  = (x[30:23] == 8'h00);
    yz  = (y[30:23] == 8'h00);
    xi  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    nan = ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) ||
          ((y[30:23] == 8'hFF) && (y[22:0] != 23'd0));
    if (nan || (xz && yz) || (xi && yi)) classify = {1'b1, 32'h7FC00000};
    else if (yz || xi)                   classify = {1'b1, s, 8'hFF, 23'd0};
    else if (xz || yi)                   classify = {1'b1, s, 31'd0};
    else                                 classify = {1'b0, 32'd0};
  endfunction

  logic [IDW-1:0]   last_q;
  logic [31:0]      x_q, y_q;
  logic             vld_q [LATENCY];
  logic [IDW-1:0]   id_q  [LATENCY];
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic [31:0]      x_sel, y_sel;
  logic             xfer;
  logic             spc_c, spc_last;
  logic [31:0]      sval_c, sval_last;
  logic             busy_c;

  // Stage 0: round-robin grant, search starting just after the last grant
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    x_sel  = '0;
    y_sel  = '0;
    xfer   = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!xfer && rstn && req_valid[i] && (i == (int'(last_q) + off) % N_REQ)) begin
          xfer   = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = IDW'(i);
          x_sel  = req_x[32*i +: 32];
          y_sel  = req_y[32*i +: 32];
        end
      end
    end
  end

  assign req_ready = gnt;
  assign {spc_c, sval_c} = classify(x_q, y_q);

  // Stage 1..LATENCY: special-case result travels with the tag
  generate
    if (LATENCY == 1) begin : g_lat1
      assign spc_last  = spc_c;
      assign sval_last = sval_c;
    end else begin : g_latn
      logic        spc_q  [1:LATENCY-1];
      logic [31:0] sval_q [1:LATENCY-1];
      always_ff @(posedge clk) begin
        spc_q[1]  <= spc_c;
        sval_q[1] <= sval_c;
        for (int k = 2; k < LATENCY; k++) begin
          spc_q[k]  <= spc_q[k-1];
          sval_q[k] <= sval_q[k-1];
        end
      end
      assign spc_last  = spc_q[LATENCY-1];
      assign sval_last = sval_q[LATENCY-1];
    end
  endgenerate

  // Output stage: one-hot response and result selection
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (vld_q[LATENCY-1]) begin
      for (int i = 0; i < N_REQ; i++)
        rsp_valid_d[i] = (id_q[LATENCY-1] == IDW'(i));
      rsp_data_d = spc_last ? sval_last : div_res;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q      <= LAST_RST;
      x_q         <= '0;
      y_q         <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k] <= 1'b0;
        id_q[k]  <= '0;
      end
    end else begin
      if (xfer) begin
        last_q <= gnt_id;
        x_q    <= x_sel;
        y_q    <= y_sel;
      end
      vld_q[0] <= xfer;
      id_q[0]  <= gnt_id;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    busy_c = |rsp_valid_q;
    for (int k = 0; k < LATENCY; k++)
      busy_c = busy_c | vld_q[k];
  end

  assign div_x     = x_q;
  assign div_y     = y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_c;

endmodule
